// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: boundary-mode enum and the
// per-cycle action classification used by the up/down counter.
package counter_pkg;

   // Boundary behaviour when a step would leave the range [0, MOD_MAX].
   typedef enum logic {
      WRAP     = 1'b0,
      SATURATE = 1'b1
   } counter_mode_e;

   // What the counter does on a given edge, in priority order.
   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_CLEAR = 2'd1,
      ACT_LOAD  = 2'd2,
      ACT_STEP  = 2'd3
   } counter_action_e;

   // Direction of an effective step request.
   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } counter_dir_e;

   // Resolve inc/dec requests into a single direction; both or neither holds.
   function automatic counter_dir_e resolve_dir(input logic up_req, input logic dn_req);
      counter_dir_e d;
      d = DIR_NONE;
      if (up_req && !dn_req) begin
         d = DIR_UP;
      end else if (dn_req && !up_req) begin
         d = DIR_DOWN;
      end
      return d;
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector. The first clock after reset release only
// captures history, so a level that is already high at release is not an edge.
module edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic in_d;
   logic armed;

   // Track previous input level and emit a one-cycle registered pulse on 0->1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_d  <= 1'b0;
         armed <= 1'b0;
         pulse <= 1'b0;
      end else begin
         in_d  <= in;
         armed <= 1'b1;
         pulse <= armed & in & ~in_d;
      end
   end

endmodule

// File: rtl/nbit_updown_counter.sv
// N-bit modulo up/down counter with clear, load, terminal-count pulses and a
// sticky overflow flag. Count range is 0..MOD_MAX; at the boundary the counter
// either wraps or saturates according to MODE. With EDGE=1 the inc/dec inputs
// act only on their rising edges (one extra cycle of latency).
module nbit_updown_counter
   import counter_pkg::*;
#(
   parameter int            N       = 4,
   parameter int            MOD_MAX = 2**N - 1,
   parameter counter_mode_e MODE    = WRAP,
   parameter bit            EDGE    = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   input  logic         ovf_clr,
   output logic [N-1:0] count,
   output logic         tc_up,
   output logic         tc_dn,
   output logic         ovf_flag
);

   localparam logic [N-1:0] MAX_V  = MOD_MAX[N-1:0];
   localparam logic [N-1:0] ZERO_V = '0;
   localparam logic [N-1:0] ONE_V  = {{(N-1){1'b0}}, 1'b1};

   logic            inc_eff;
   logic            dec_eff;
   counter_action_e action;
   counter_dir_e    dir;
   logic [N-1:0]    load_clamped;
   logic [N-1:0]    count_nxt;
   logic            tc_up_nxt;
   logic            tc_dn_nxt;
   logic            ovf_nxt;

   // Select level-sensitive or edge-qualified step requests.
   if (EDGE) begin : g_edge
      edge_detect u_inc_edge (
         .clk   (clk),
         .reset (reset),
         .in    (inc),
         .pulse (inc_eff)
      );
      edge_detect u_dec_edge (
         .clk   (clk),
         .reset (reset),
         .in    (dec),
         .pulse (dec_eff)
      );
   end else begin : g_level
      assign inc_eff = inc;
      assign dec_eff = dec;
   end

   // A load never lets the count leave the legal range.
   assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

   // Classify this cycle: clear beats load beats step beats hold.
   always_comb begin
      dir    = resolve_dir(inc_eff, dec_eff);
      action = ACT_HOLD;
      if (clear) begin
         action = ACT_CLEAR;
      end else if (load) begin
         action = ACT_LOAD;
      end else if (dir != DIR_NONE) begin
         action = ACT_STEP;
      end
   end

   // Next count and terminal-count events; only a real step can raise a pulse.
   always_comb begin
      count_nxt = count;
      tc_up_nxt = 1'b0;
      tc_dn_nxt = 1'b0;
      case (action)
         ACT_CLEAR: count_nxt = ZERO_V;
         ACT_LOAD:  count_nxt = load_clamped;
         ACT_STEP: begin
            if (dir == DIR_UP) begin
               if (count >= MAX_V) begin
                  tc_up_nxt = 1'b1;
                  count_nxt = (MODE == WRAP) ? ZERO_V : MAX_V;
               end else begin
                  count_nxt = count + ONE_V;
               end
            end else if (dir == DIR_DOWN) begin
               if (count == ZERO_V) begin
                  tc_dn_nxt = 1'b1;
                  count_nxt = (MODE == WRAP) ? MAX_V : ZERO_V;
               end else begin
                  count_nxt = count - ONE_V;
               end
            end
         end
         default: count_nxt = count;
      endcase
   end

   // Sticky overflow: a new event in the same cycle outranks ovf_clr.
   always_comb begin
      ovf_nxt = ovf_flag;
      if (tc_up_nxt || tc_dn_nxt) begin
         ovf_nxt = 1'b1;
      end else if (ovf_clr) begin
         ovf_nxt = 1'b0;
      end
   end

   // State and output registers; reset is asynchronous.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count    <= ZERO_V;
         tc_up    <= 1'b0;
         tc_dn    <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         count    <= count_nxt;
         tc_up    <= tc_up_nxt;
         tc_dn    <= tc_dn_nxt;
         ovf_flag <= ovf_nxt;
      end
   end

endmodule
